multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode, execute, memory and
// writeback, with per-request acknowledge timeouts that latch a bus-error halt.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic       rf_waddr_sel,
  output logic [1:0] rf_wdata_sel,
  output logic [1:0] imm_sel,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  // Last wait cycle index (counter starts at 0 on the first wait cycle).
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t     state, state_n;
  logic [7:0] wait_cnt;
  logic       timeout;

  logic       legal, is_r, is_lui, is_j, is_lw, is_sw, is_br, is_beq, use_imm;
  logic [3:0] alu_op_dec;
  logic [1:0] imm_dec;

  assign timeout = (wait_cnt == LAST_WAIT);

  always_comb begin
    legal      = 1'b1;
    is_r       = 1'b0;
    is_lui     = 1'b0;
    is_j       = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_br      = 1'b0;
    is_beq     = 1'b0;
    use_imm    = 1'b0;
    alu_op_dec = ALU_ADD;
    imm_dec    = 2'b00;
    case (opcode)
      OP_R: begin
        is_r = 1'b1;
        case (funct)
          6'b100000: alu_op_dec = ALU_ADD;
          6'b100010: alu_op_dec = ALU_SUB;
          6'b100100: alu_op_dec = ALU_AND;
          6'b100101: alu_op_dec = ALU_OR;
          6'b101010: alu_op_dec = ALU_SLT;
          default:   legal      = 1'b0;
        endcase
      end
      OP_ADDI: use_imm = 1'b1;
      OP_ANDI: begin use_imm = 1'b1; alu_op_dec = ALU_AND; imm_dec = 2'b01; end
      OP_ORI:  begin use_imm = 1'b1; alu_op_dec = ALU_OR;  imm_dec = 2'b01; end
      OP_LUI:  is_lui = 1'b1;
      OP_LW:   begin is_lw = 1'b1; use_imm = 1'b1; end
      OP_SW:   begin is_sw = 1'b1; use_imm = 1'b1; end
      OP_BEQ:  begin is_br = 1'b1; is_beq = 1'b1; alu_op_dec = ALU_SUB; end
      OP_BNE:  begin is_br = 1'b1; alu_op_dec = ALU_SUB; end
      OP_J:    is_j = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_n;
      if (state_n != state)
        wait_cnt <= 8'd0;
      else if (state == FETCH || state == MEM)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_n      = state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    rf_we        = 1'b0;
    rf_waddr_sel = 1'b0;
    rf_wdata_sel = 2'b00;
    imm_sel      = 2'b00;
    alu_src      = 1'b0;
    alu_op       = 4'b0000;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    halted       = 1'b0;
    // Strobes stay quiet for the whole reset cycle so no in-flight write leaks out.
    if (!reset) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_n = DECODE;
          end else if (timeout) begin
            state_n = HALT;
          end
        end
        DECODE: begin
          if (!legal) begin
            illegal = 1'b1;
            state_n = FETCH;
          end else if (is_j) begin
            pc_we   = 1'b1;
            pc_sel  = 2'b10;
            state_n = FETCH;
          end else if (is_lui) begin
            state_n = WB;
          end else begin
            state_n = EXEC;
          end
        end
        EXEC: begin
          alu_op  = alu_op_dec;
          imm_sel = imm_dec;
          alu_src = use_imm;
          if (is_br) begin
            if (is_beq ? alu_zero : !alu_zero) begin
              pc_we  = 1'b1;
              pc_sel = 2'b01;
            end
            state_n = FETCH;
          end else if (is_lw || is_sw) begin
            state_n = MEM;
          end else begin
            state_n = WB;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
          if (dmem_ack)
            state_n = is_lw ? WB : FETCH;
          else if (timeout)
            state_n = HALT;
        end
        WB: begin
          rf_we        = 1'b1;
          rf_waddr_sel = is_r;
          rf_wdata_sel = is_lw ? 2'b01 : (is_lui ? 2'b10 : 2'b00);
          state_n      = FETCH;
        end
        HALT: begin
          bus_err = 1'b1;
          halted  = 1'b1;
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle pushes a hand-derived output
// vector; a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       alu_zero, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0] pc_sel;
  logic       rf_we, rf_waddr_sel;
  logic [1:0] rf_wdata_sel, imm_sel;
  logic       alu_src;
  logic [3:0] alu_op;
  logic       illegal, bus_err, halted;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .rf_waddr_sel(rf_waddr_sel), .rf_wdata_sel(rf_wdata_sel), .imm_sel(imm_sel),
    .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       rf_we, rf_waddr_sel;
    logic [1:0] rf_wdata_sel, imm_sel;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       illegal, bus_err, halted;
  } out_t;

  out_t act;
  assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, rf_waddr_sel,
                rf_wdata_sel, imm_sel, alu_src, alu_op, illegal, bus_err, halted};

  out_t  exp_q[$];
  string tag_q[$];
  int    n_chk = 0, n_pass = 0;
  out_t  mon_e;
  string mon_t;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      n_chk++;
      if (act === mon_e) n_pass++;
      else $display("FAIL %s: got %h expected %h", mon_t, act, mon_e);
    end
  end

  function automatic out_t zero(); out_t o = '0; return o; endfunction
  function automatic out_t f_wait(); out_t o = '0; o.imem_req = 1; return o; endfunction
  function automatic out_t f_ack();
    out_t o = '0; o.imem_req = 1; o.ir_we = 1; o.pc_we = 1; return o;
  endfunction
  function automatic out_t d_j(); out_t o = '0; o.pc_we = 1; o.pc_sel = 2'b10; return o; endfunction
  function automatic out_t d_ill(); out_t o = '0; o.illegal = 1; return o; endfunction
  function automatic out_t ex(input logic src, input logic [1:0] imm, input logic [3:0] op);
    out_t o = '0; o.alu_src = src; o.imm_sel = imm; o.alu_op = op; return o;
  endfunction
  function automatic out_t ex_br(input logic taken);
    out_t o = '0; o.alu_op = 4'b0001; o.pc_we = taken; o.pc_sel = taken ? 2'b01 : 2'b00; return o;
  endfunction
  function automatic out_t mem(input logic we);
    out_t o = '0; o.dmem_req = 1; o.dmem_we = we; return o;
  endfunction
  function automatic out_t wb(input logic a, input logic [1:0] d);
    out_t o = '0; o.rf_we = 1; o.rf_waddr_sel = a; o.rf_wdata_sel = d; return o;
  endfunction
  function automatic out_t halt_o(); out_t o = '0; o.bus_err = 1; o.halted = 1; return o; endfunction

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  task automatic cyc(input string t, input logic ia, input logic da, input logic az, input out_t e);
    reset = 0; imem_ack = ia; dmem_ack = da; alu_zero = az;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk); #1;
  endtask

  task automatic rcyc(input string t, input out_t e);
    reset = 1; imem_ack = 0; dmem_ack = 0; alu_zero = 0;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk); #1;
  endtask

  // Zero-wait ALU-class instruction: FETCH, DECODE, EXEC, WB.
  task automatic alu4(input string t, input logic [5:0] op, input logic [5:0] fn,
                      input out_t e_ex, input out_t e_wb);
    instr(op, fn);
    cyc({t, " fetch"}, 1, 0, 0, f_ack());
    cyc({t, " decode"}, 0, 0, 0, zero());
    cyc({t, " exec"}, 0, 0, 0, e_ex);
    cyc({t, " wb"}, 0, 0, 0, e_wb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; opcode = 0; funct = 0; alu_zero = 0; imem_ack = 0; dmem_ack = 0;
    @(posedge clk); #1;
    rcyc("reset0", zero());
    rcyc("reset1", zero());

    // lui: FETCH, DECODE, WB
    instr(6'b001111, 6'b000000);
    cyc("lui fetch", 1, 0, 0, f_ack());
    cyc("lui decode", 0, 0, 0, zero());
    cyc("lui wb", 0, 0, 0, wb(0, 2'b10));

    alu4("add", 6'b000000, 6'b100000, ex(0, 2'b00, 4'b0000), wb(1, 2'b00));
    // one imem wait cycle with a stray dmem_ack that must be ignored
    instr(6'b000000, 6'b100010);
    cyc("sub fetch wait", 0, 1, 0, f_wait());
    cyc("sub fetch", 1, 0, 0, f_ack());
    cyc("sub decode", 0, 0, 0, zero());
    cyc("sub exec", 0, 0, 0, ex(0, 2'b00, 4'b0001));
    cyc("sub wb", 0, 0, 0, wb(1, 2'b00));
    alu4("slt", 6'b000000, 6'b101010, ex(0, 2'b00, 4'b0100), wb(1, 2'b00));
    alu4("or", 6'b000000, 6'b100101, ex(0, 2'b00, 4'b0011), wb(1, 2'b00));
    alu4("addi", 6'b001000, 6'b000000, ex(1, 2'b00, 4'b0000), wb(0, 2'b00));
    alu4("andi", 6'b001100, 6'b111111, ex(1, 2'b01, 4'b0010), wb(0, 2'b00));
    alu4("ori", 6'b001101, 6'b000000, ex(1, 2'b01, 4'b0011), wb(0, 2'b00));

    // lw with dmem_ack delayed 3 cycles: 8 cycles total
    instr(6'b100011, 6'b000000);
    cyc("lw fetch", 1, 0, 0, f_ack());
    cyc("lw decode", 0, 0, 0, zero());
    cyc("lw exec", 0, 0, 0, ex(1, 2'b00, 4'b0000));
    for (int i = 0; i < 3; i++) cyc("lw mem wait", 0, 0, 0, mem(0));
    cyc("lw mem ack", 0, 1, 0, mem(0));
    cyc("lw wb", 0, 0, 0, wb(0, 2'b01));

    // sw zero-wait: returns to FETCH after MEM
    instr(6'b101011, 6'b000000);
    cyc("sw fetch", 1, 0, 0, f_ack());
    cyc("sw decode", 0, 0, 0, zero());
    cyc("sw exec", 0, 0, 0, ex(1, 2'b00, 4'b0000));
    cyc("sw mem ack", 0, 1, 0, mem(1));

    // branches
    instr(6'b000100, 6'b000000);
    cyc("beq fetch", 1, 0, 0, f_ack());
    cyc("beq decode", 0, 0, 0, zero());
    cyc("beq z=1 exec", 0, 0, 1, ex_br(1));
    instr(6'b000101, 6'b000000);
    cyc("bne fetch", 1, 0, 0, f_ack());
    cyc("bne decode", 0, 0, 0, zero());
    cyc("bne z=1 exec", 0, 0, 1, ex_br(0));
    cyc("bne2 fetch", 1, 0, 0, f_ack());
    cyc("bne2 decode", 0, 0, 0, zero());
    cyc("bne z=0 exec", 0, 0, 0, ex_br(1));

    // jump
    instr(6'b000010, 6'b000000);
    cyc("j fetch", 1, 0, 0, f_ack());
    cyc("j decode", 0, 0, 0, d_j());

    // illegal opcode and illegal R-type funct
    instr(6'b111111, 6'b000000);
    cyc("ill op fetch", 1, 0, 0, f_ack());
    cyc("ill op decode", 0, 0, 0, d_ill());
    instr(6'b000000, 6'b000000);
    cyc("ill funct fetch", 1, 0, 0, f_ack());
    cyc("ill funct decode", 0, 0, 0, d_ill());

    // reset during sw MEM wait: write strobe dropped, restart in FETCH
    instr(6'b101011, 6'b000000);
    cyc("swr fetch", 1, 0, 0, f_ack());
    cyc("swr decode", 0, 0, 0, zero());
    cyc("swr exec", 0, 0, 0, ex(1, 2'b00, 4'b0000));
    cyc("swr mem wait", 0, 0, 0, mem(1));
    cyc("swr mem wait2", 0, 0, 0, mem(1));
    rcyc("swr reset", zero());
    cyc("swr refetch", 0, 1, 0, f_wait());

    // imem ack on the 15th wait cycle is still accepted
    instr(6'b000010, 6'b000000);
    for (int i = 0; i < 13; i++) cyc("fetch wait", 0, 0, 0, f_wait());
    cyc("fetch ack at limit", 1, 0, 0, f_ack());
    cyc("j after limit", 0, 0, 0, d_j());

    // lw with no dmem_ack: HALT after 15 MEM cycles, late ack ignored
    instr(6'b100011, 6'b000000);
    cyc("lwto fetch", 1, 0, 0, f_ack());
    cyc("lwto decode", 0, 0, 0, zero());
    cyc("lwto exec", 0, 0, 0, ex(1, 2'b00, 4'b0000));
    for (int i = 0; i < 15; i++) cyc("lwto mem wait", 0, 0, 0, mem(0));
    cyc("lwto halt", 0, 0, 0, halt_o());
    cyc("lwto late ack", 0, 1, 0, halt_o());
    rcyc("lwto reset", zero());

    // imem_ack held low: HALT after 15 wait cycles, late ack ignored, reset recovers
    for (int i = 0; i < 15; i++) cyc("imem timeout wait", 0, 0, 0, f_wait());
    cyc("imem halt", 0, 0, 0, halt_o());
    cyc("imem late ack", 1, 0, 0, halt_o());
    cyc("imem still halted", 1, 1, 0, halt_o());
    rcyc("halt reset", zero());
    instr(6'b000010, 6'b000000);
    cyc("recover fetch", 1, 0, 0, f_ack());
    cyc("recover decode", 0, 0, 0, d_j());
    cyc("recover refetch", 0, 0, 0, f_wait());

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
